decode_stage: RTL and testbench

//  Registered, parametrised MIPS decode stage for the pipelined CPU; sits between the fetch queue and execute.

---
 rtl/decode_stage.sv | 188 ++++++++++++++++++
 tb/tb_decode_stage.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// MIPS decode stage: instruction word to registered control bundle, 1-cycle latency.
// Backpressure: valid/ready on both sides; bundle held while !out_ready, input stalled on load-use hazard.
module decode_stage #(
    parameter int         XLEN         = 32,
    parameter int         STALL_CYCLES = 1,
    parameter logic [4:0] RA_REG       = 5'd31
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs,
    output logic [4:0]      out_rt,
    output logic [4:0]      out_wreg,
    output logic [XLEN-1:0] out_imm,
    output logic            out_regwr,
    output logic            out_memwr,
    output logic            out_memtoreg,
    output logic            out_branch,
    output logic            out_invzero,
    output logic            out_jump,
    output logic            out_jumpreg,
    output logic [1:0]      out_alusrc,
    output logic [2:0]      out_aluctl,
    output logic            out_illegal
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23, OP_SW  = 6'h2B;
    localparam logic [5:0] FN_JR  = 6'h08, FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SLT = 6'h2A;
    localparam logic [1:0] SRC_IMM = 2'b00, SRC_PC = 2'b01, SRC_DB = 2'b10;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_SLT = 3'd3;
    localparam int CW = (STALL_CYCLES < 1) ? 1 : $clog2(STALL_CYCLES + 1);
    localparam logic [CW-1:0] STALL_INIT = CW'(STALL_CYCLES);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      wreg;
        logic [XLEN-1:0] imm;
        logic            regwr;
        logic            memwr;
        logic            memtoreg;
        logic            branch;
        logic            invzero;
        logic            jump;
        logic            jumpreg;
        logic [1:0]      alusrc;
        logic [2:0]      aluctl;
        logic            illegal;
    } bundle_t;

    bundle_t         dec;
    bundle_t         held;
    logic            reads_rs;
    logic            reads_rt;
    logic            hazard;
    logic            accept;
    logic            xfer;
    logic [CW-1:0]   cnt;
    logic [4:0]      ld_dest;
    logic [5:0]      opcode;
    logic [5:0]      funct;

    assign opcode = in_instr[31:26];
    assign funct  = in_instr[5:0];

    always_comb begin
        dec          = '0;
        dec.pc       = in_pc;
        dec.rs       = in_instr[25:21];
        dec.rt       = in_instr[20:16];
        dec.imm      = {{(XLEN-16){in_instr[15]}}, in_instr[15:0]};
        reads_rs     = 1'b0;
        reads_rt     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU, FN_ADD, FN_SUB, FN_SLT: begin
                        dec.wreg   = in_instr[15:11];
                        dec.regwr  = 1'b1;
                        dec.alusrc = SRC_DB;
                        dec.aluctl = (funct == FN_SUB) ? ALU_SUB :
                                     (funct == FN_SLT) ? ALU_SLT : ALU_ADD;
                        reads_rs   = 1'b1;
                        reads_rt   = 1'b1;
                    end
                    FN_JR: begin
                        dec.jumpreg = 1'b1;
                        reads_rs    = 1'b1;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW: begin
                dec.wreg     = in_instr[20:16];
                dec.regwr    = 1'b1;
                dec.memtoreg = (opcode == OP_LW);
                dec.alusrc   = SRC_IMM;
                dec.aluctl   = ALU_ADD;
                reads_rs     = 1'b1;
            end
            OP_SW: begin
                dec.memwr  = 1'b1;
                dec.alusrc = SRC_IMM;
                dec.aluctl = ALU_ADD;
                reads_rs   = 1'b1;
                reads_rt   = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec.branch  = 1'b1;
                dec.invzero = (opcode == OP_BNE);
                dec.alusrc  = SRC_DB;
                dec.aluctl  = ALU_SUB;
                reads_rs    = 1'b1;
                reads_rt    = 1'b1;
            end
            OP_J, OP_JAL: begin
                dec.jump = 1'b1;
                dec.imm  = XLEN'({in_instr[25:0], 2'b00});
                if (opcode == OP_JAL) begin
                    dec.regwr  = 1'b1;
                    dec.wreg   = RA_REG;
                    dec.alusrc = SRC_PC;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // ld_dest is only loaded with a nonzero register, so $0 never matches a live load
    assign hazard = (STALL_CYCLES != 0) && (cnt != '0) && (ld_dest != 5'd0) &&
                    ((reads_rs && (dec.rs == ld_dest)) || (reads_rt && (dec.rt == ld_dest)));

    assign in_ready = !reset && (flush || ((!out_valid || out_ready) && !hazard));
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            held      <= '0;
            cnt       <= '0;
            ld_dest   <= 5'd0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                held      <= dec;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end

            if (flush) begin
                cnt <= '0;
            end else if (xfer && held.memtoreg && (held.wreg != 5'd0)) begin
                ld_dest <= held.wreg;
                cnt     <= STALL_INIT;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign out_pc       = held.pc;
    assign out_rs       = held.rs;
    assign out_rt       = held.rt;
    assign out_wreg     = held.wreg;
    assign out_imm      = held.imm;
    assign out_regwr    = held.regwr;
    assign out_memwr    = held.memwr;
    assign out_memtoreg = held.memtoreg;
    assign out_branch   = held.branch;
    assign out_invzero  = held.invzero;
    assign out_jump     = held.jump;
    assign out_jumpreg  = held.jumpreg;
    assign out_alusrc   = held.alusrc;
    assign out_aluctl   = held.aluctl;
    assign out_illegal  = held.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: table-driven decode vectors through a scoreboard, plus stall/flush/reset sequences.
module tb_decode_stage;
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wreg;
        logic [31:0] imm;
        logic        regwr;
        logic        memwr;
        logic        memtoreg;
        logic        branch;
        logic        invzero;
        logic        jump;
        logic        jumpreg;
        logic [1:0]  alusrc;
        logic [2:0]  aluctl;
        logic        illegal;
    } bund_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [4:0]  wreg;
        logic [31:0] imm;
        logic [12:0] ctl;
    } vec_t;

    // ctl = {regwr,memwr,memtoreg,branch,invzero,jump,jumpreg, alusrc[1:0], aluctl[2:0], illegal}
    localparam logic [12:0] C_ADD  = 13'b1000000_10_000_0;
    localparam logic [12:0] C_SUB  = 13'b1000000_10_001_0;
    localparam logic [12:0] C_SLT  = 13'b1000000_10_011_0;
    localparam logic [12:0] C_JR   = 13'b0000001_00_000_0;
    localparam logic [12:0] C_ADDI = 13'b1000000_00_000_0;
    localparam logic [12:0] C_LW   = 13'b1010000_00_000_0;
    localparam logic [12:0] C_SW   = 13'b0100000_00_000_0;
    localparam logic [12:0] C_BEQ  = 13'b0001000_10_001_0;
    localparam logic [12:0] C_BNE  = 13'b0001100_10_001_0;
    localparam logic [12:0] C_J    = 13'b0000010_00_000_0;
    localparam logic [12:0] C_JAL  = 13'b1000010_01_000_0;
    localparam logic [12:0] C_ILL  = 13'b0000000_00_000_1;
    localparam int NV = 19;

    logic        clk = 1'b0;
    logic        reset, in_valid, flush, out_ready;
    logic [31:0] in_instr, in_pc;
    logic        ra, rb, va, vb;
    bund_t       oa, ob;

    vec_t        vt [NV];
    bund_t       sbq [$];
    bund_t       pending, last_b, e0, e1;
    logic        last_vld, last_rdy, last_acc;
    int          sel, nstall;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .STALL_CYCLES(1), .RA_REG(5'd31)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ra), .in_instr(in_instr),
        .in_pc(in_pc), .flush(flush), .out_valid(va), .out_ready(out_ready), .out_pc(oa.pc),
        .out_rs(oa.rs), .out_rt(oa.rt), .out_wreg(oa.wreg), .out_imm(oa.imm), .out_regwr(oa.regwr),
        .out_memwr(oa.memwr), .out_memtoreg(oa.memtoreg), .out_branch(oa.branch),
        .out_invzero(oa.invzero), .out_jump(oa.jump), .out_jumpreg(oa.jumpreg),
        .out_alusrc(oa.alusrc), .out_aluctl(oa.aluctl), .out_illegal(oa.illegal));

    decode_stage #(.XLEN(32), .STALL_CYCLES(2), .RA_REG(5'd31)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rb), .in_instr(in_instr),
        .in_pc(in_pc), .flush(flush), .out_valid(vb), .out_ready(out_ready), .out_pc(ob.pc),
        .out_rs(ob.rs), .out_rt(ob.rt), .out_wreg(ob.wreg), .out_imm(ob.imm), .out_regwr(ob.regwr),
        .out_memwr(ob.memwr), .out_memtoreg(ob.memtoreg), .out_branch(ob.branch),
        .out_invzero(ob.invzero), .out_jump(ob.jump), .out_jumpreg(ob.jumpreg),
        .out_alusrc(ob.alusrc), .out_aluctl(ob.aluctl), .out_illegal(ob.illegal));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input bund_t act, input bund_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bund_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [4:0] wreg, input logic [31:0] imm, input logic [12:0] ctl);
        bund_t b;
        b.pc   = pc;
        b.rs   = instr[25:21];
        b.rt   = instr[20:16];
        b.wreg = wreg;
        b.imm  = imm;
        {b.regwr, b.memwr, b.memtoreg, b.branch, b.invzero, b.jump, b.jumpreg,
         b.alusrc, b.aluctl, b.illegal} = ctl;
        return b;
    endfunction

    function automatic bund_t ev(input int i, input logic [31:0] pc);
        return mk(vt[i].instr, pc, vt[i].wreg, vt[i].imm, vt[i].ctl);
    endfunction

    // Sampled on the falling edge: scoreboard pops on output transfer, pushes on input accept.
    task automatic sample();
        bund_t b;
        logic  v, r;
        b = (sel != 0) ? ob : oa;
        v = (sel != 0) ? vb : va;
        r = (sel != 0) ? rb : ra;
        last_b = b; last_vld = v; last_rdy = r; last_acc = in_valid && r;
        if (in_valid && !r) nstall++;
        if (reset) return;
        if (v && out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got bundle %h expected none", b);
            end else begin
                chk_b("sb_bundle", b, sbq.pop_front());
            end
        end
        if (flush) sbq.delete();
        else if (in_valid && r) sbq.push_back(pending);
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        sbq.delete();
    endtask

    task automatic send(input logic [31:0] instr, input bund_t e);
        in_valid = 1'b1; in_instr = instr; in_pc = e.pc; pending = e;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (last_acc) break;
        end
        chk("accept", last_acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic hz_run(input int s, input int li, input int di, input int exp_st);
        sel = s;
        do_reset();
        send(vt[li].instr, ev(li, 32'h100));
        idle(1);
        nstall = 0;
        send(vt[di].instr, ev(di, 32'h104));
        chk("hz_stalls", nstall, exp_st);
        idle(2);
        chk("hz_drain", sbq.size(), 0);
    endtask

    task automatic lw_then_dep_held();
        send(vt[7].instr, ev(7, 32'h200));
        send(vt[1].instr, ev(1, 32'h204));
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = vt[16].instr; in_pc = 32'h208; pending = ev(16, 32'h208);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{"addu",   32'h00221821, 5'd3,  32'h00001821, C_ADD};
        vt[1]  = '{"add",    32'h00A62020, 5'd4,  32'h00002020, C_ADD};
        vt[2]  = '{"sub",    32'h01093822, 5'd7,  32'h00003822, C_SUB};
        vt[3]  = '{"slt",    32'h016C502A, 5'd10, 32'h0000502A, C_SLT};
        vt[4]  = '{"jr",     32'h03E00008, 5'd0,  32'h00000008, C_JR};
        vt[5]  = '{"addi",   32'h20C5FFFD, 5'd5,  32'hFFFFFFFD, C_ADDI};
        vt[6]  = '{"addiu",  32'h24077FFF, 5'd7,  32'h00007FFF, C_ADDI};
        vt[7]  = '{"lw",     32'h8C220004, 5'd2,  32'h00000004, C_LW};
        vt[8]  = '{"sw",     32'hAC83FFF8, 5'd0,  32'hFFFFFFF8, C_SW};
        vt[9]  = '{"beq",    32'h10220008, 5'd0,  32'h00000008, C_BEQ};
        vt[10] = '{"bne",    32'h1422FFFF, 5'd0,  32'hFFFFFFFF, C_BNE};
        vt[11] = '{"j",      32'h08000400, 5'd0,  32'h00001000, C_J};
        vt[12] = '{"jal",    32'h0C000100, 5'd31, 32'h00000400, C_JAL};
        vt[13] = '{"ill_op", 32'hFC000000, 5'd0,  32'h00000000, C_ILL};
        vt[14] = '{"ill_fn", 32'h0022183F, 5'd0,  32'h0000183F, C_ILL};
        vt[15] = '{"lw_r0",  32'h8C200004, 5'd0,  32'h00000004, C_LW};
        vt[16] = '{"dep",    32'h00421821, 5'd3,  32'h00001821, C_ADD};
        vt[17] = '{"indep",  32'h00211821, 5'd3,  32'h00001821, C_ADD};
        vt[18] = '{"zero",   32'h00001821, 5'd3,  32'h00001821, C_ADD};

        // reset state and first-instruction latency
        sel = 0; nstall = 0;
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_instr = vt[0].instr; in_pc = 32'h40;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rst_in_ready", last_rdy, 1'b0);
            chk("rst_out_valid", last_vld, 1'b0);
            chk_b("rst_bundle", last_b, '0);
        end
        reset = 1'b0;
        sbq.delete();
        pending = ev(0, 32'h40);
        tick();
        chk("lat_accept", last_acc, 1'b1);
        chk("lat_out_valid", va, 1'b1);
        idle(2);

        // every decode vector through the scoreboard
        do_reset();
        for (int i = 0; i < NV; i++) send(vt[i].instr, ev(i, 32'h00400000 + 32'(i * 4)));
        idle(3);
        chk("table_drain", sbq.size(), 0);

        // load-use interlock: STALL_CYCLES 1 and 2, independent reader, load to $0
        hz_run(0, 7, 16, 1);
        hz_run(1, 7, 16, 2);
        hz_run(0, 7, 17, 0);
        hz_run(1, 15, 18, 0);

        // held bundle with backpressure, then back-to-back release
        sel = 0;
        do_reset();
        e0 = ev(0, 32'h300);
        e1 = ev(1, 32'h304);
        send(vt[0].instr, e0);
        out_ready = 1'b0; in_valid = 1'b1; in_instr = vt[1].instr; in_pc = 32'h304; pending = e1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_valid", last_vld, 1'b1);
            chk_b("hold_stable", last_b, e0);
            chk("hold_in_ready", last_rdy, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        chk("release_rdy", last_rdy, 1'b1);
        in_valid = 1'b0;
        tick();
        chk("b2b_valid", last_vld, 1'b1);
        idle(1);
        chk("hold_drain", sbq.size(), 0);

        // flush with a held bundle during a load stall
        sel = 1;
        do_reset();
        lw_then_dep_held();
        chk("held_hz_rdy", rb, 1'b0);
        flush = 1'b1;
        #1;
        chk("flush_rdy", rb, 1'b1);
        tick();
        flush = 1'b0;
        chk("flush_kill", vb, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("flush_cnt_clr", last_rdy, 1'b1);
        idle(2);
        chk("flush_drain", sbq.size(), 0);

        // reset in the middle of a stall with a held bundle
        do_reset();
        lw_then_dep_held();
        reset = 1'b1;
        tick();
        chk("rst_mid_rdy", last_rdy, 1'b0);
        reset = 1'b0;
        sbq.delete();
        chk("rst_mid_vld", vb, 1'b0);
        chk_b("rst_mid_bundle", ob, '0);
        out_ready = 1'b1;
        tick();
        chk("rst_mid_cnt_clr", last_rdy, 1'b1);
        idle(2);
        chk("rst_mid_drain", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
